vga_pixel_pipe: RTL and testbench

VGA_PIXEL_PIPE -- requirements
Module: vga_pixel_pipe

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_pixel_pipe_if.sv | 9 +
 rtl/vga_palette.sv | 25 ++
 rtl/vga_pixel_pipe_fetch.sv | 83 ++++++++
 rtl/vga_pixel_pipe.sv | 142 ++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 295 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/vga_pkg.sv
// Shared types, default window geometry and colour helpers for the VGA pixel pipe.
package vga_pkg;

    typedef logic [23:0] rgb24_t;

    typedef enum logic {
        StWaitFrame,
        StRun
    } state_e;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_b;
    } timing_t;

    localparam int unsigned WIN_X0_DEF     = 196;
    localparam int unsigned WIN_Y0_DEF     = 116;
    localparam int unsigned WIN_W_DEF      = 253;
    localparam int unsigned WIN_H_DEF      = 249;
    localparam rgb24_t      BORDER_RGB_DEF = 24'h202020;

    localparam timing_t TIMING_RESET = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0};

    function automatic rgb24_t rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read bus: the fetch stage is master, the external framebuffer is slave.
interface vga_pixel_pipe_if;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_palette.sv
// 256 x 24-bit colour palette: synchronous write, registered read.
module vga_palette
    import vga_pkg::*;
(
    input  logic       vgaclk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  rgb24_t     wdata,
    input  logic [7:0] raddr,
    output rgb24_t     rdata
);
    rgb24_t mem_q [256];
    rgb24_t rdata_q;

    // No reset: palette contents must survive rst.
    always_ff @(posedge vgaclk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_pixel_pipe_fetch.sv
// Stage 1 of the pixel pipe: frame-sync FSM, window pixel counter, framebuffer read
// strobe, frame_done pulse and the sticky pixel-count error flag.
module vga_pixel_pipe_fetch
    import vga_pkg::*;
#(
    parameter logic [15:0] PIX_TOTAL = 16'd62997
) (
    input  logic             vgaclk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             hold_in,
    input  logic             blank_b_in,
    vga_pixel_pipe_if.master fb,
    output logic             frame_done,
    output logic             err
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        rd_en_q, rd_en_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;
    logic        frame_start;
    logic        running;
    logic [15:0] base;

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        frame_start = (x == 10'd0) && (y == 10'd0);

        unique case (state_q)
            StWaitFrame: if (frame_start) state_d = StRun;
            StRun:       state_d = StRun;
        endcase

        running = (state_q == StRun) || frame_start;

        // A frame start that interrupts a partly fetched window means a short/long frame.
        if (frame_start && (state_q == StRun) && (cnt_q != 16'd0) && (cnt_q != PIX_TOTAL)) begin
            err_d = 1'b1;
        end

        base         = frame_start ? 16'd0 : cnt_q;
        rd_en_d      = running && !hold_in && blank_b_in;
        rd_addr_d    = base;
        cnt_d        = base;
        frame_done_d = rd_en_d && (base == PIX_TOTAL - 16'd1);

        if (rd_en_d) begin
            if (base == 16'hFFFF) begin
                err_d = 1'b1;
            end else begin
                cnt_d = base + 16'd1;
            end
        end
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q      <= StWaitFrame;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign fb.rd_en    = rd_en_q;
    assign fb.rd_addr  = rd_addr_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;

endmodule

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipe: 3-cycle fetch/colour pipeline from timing position to RGB and syncs.
// Define VGA_PIXEL_PALETTE_EN to map framebuffer bytes through a palette instead of RGB332.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int unsigned WIN_X0     = WIN_X0_DEF,
    parameter int unsigned WIN_Y0     = WIN_Y0_DEF,
    parameter int unsigned WIN_W      = WIN_W_DEF,
    parameter int unsigned WIN_H      = WIN_H_DEF,
    parameter rgb24_t      BORDER_RGB = BORDER_RGB_DEF
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_b_in,
    input  logic        hold_in,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_wdata,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_b,
    output logic        sync_b,
    output logic        frame_done,
    output logic        err
);
    localparam logic [15:0] PixTotal = 16'(WIN_W * WIN_H);
    // The window origin is decoded upstream into hold_in.
    localparam int unsigned unused_win_origin = WIN_X0 + WIN_Y0;

    vga_pixel_pipe_if fb_bus ();

    vga_pixel_pipe_fetch #(
        .PIX_TOTAL(PixTotal)
    ) u_fetch (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .hold_in   (hold_in),
        .blank_b_in(blank_b_in),
        .fb        (fb_bus),
        .frame_done(frame_done),
        .err       (err)
    );

    assign rd_en          = fb_bus.rd_en;
    assign rd_addr        = fb_bus.rd_addr;
    assign fb_bus.rd_data = rd_data;

    timing_t    tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
    logic [7:0] data2_q, data2_d;
    logic       win2_q, win2_d;
    logic       sync_b3_q, sync_b3_d;
    rgb24_t     rgb3_q, rgb3_d;
    rgb24_t     rgb_out;
`ifdef VGA_PIXEL_PALETTE_EN
    logic       win3_q, win3_d;
    rgb24_t     pal_rgb;
`endif

    always_comb begin
        tim1_d    = '{hsync: hsync_in, vsync: vsync_in, blank_b: blank_b_in};
        tim2_d    = tim1_q;
        tim3_d    = tim2_q;
        data2_d   = fb_bus.rd_data;
        win2_d    = fb_bus.rd_en;
        sync_b3_d = tim2_q.hsync & tim2_q.vsync;
        rgb3_d    = '0;
        if (win2_q) begin
`ifndef VGA_PIXEL_PALETTE_EN
            rgb3_d = rgb332_expand(data2_q);
`endif
        end else if (tim2_q.blank_b) begin
            rgb3_d = BORDER_RGB;
        end
`ifdef VGA_PIXEL_PALETTE_EN
        win3_d = win2_q;
`endif
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            tim1_q    <= TIMING_RESET;
            tim2_q    <= TIMING_RESET;
            tim3_q    <= TIMING_RESET;
            data2_q   <= '0;
            win2_q    <= 1'b0;
            sync_b3_q <= 1'b1;
            rgb3_q    <= '0;
`ifdef VGA_PIXEL_PALETTE_EN
            win3_q    <= 1'b0;
`endif
        end else begin
            tim1_q    <= tim1_d;
            tim2_q    <= tim2_d;
            tim3_q    <= tim3_d;
            data2_q   <= data2_d;
            win2_q    <= win2_d;
            sync_b3_q <= sync_b3_d;
            rgb3_q    <= rgb3_d;
`ifdef VGA_PIXEL_PALETTE_EN
            win3_q    <= win3_d;
`endif
        end
    end

`ifdef VGA_PIXEL_PALETTE_EN
    // The palette's registered read is the stage-3 register for window pixels.
    vga_palette u_palette (
        .vgaclk(vgaclk),
        .we    (pal_we),
        .waddr (pal_addr),
        .wdata (pal_wdata),
        .raddr (data2_q),
        .rdata (pal_rgb)
    );
    assign rgb_out = win3_q ? pal_rgb : rgb3_q;
`else
    logic unused_pal;
    assign unused_pal = ^{pal_we, pal_addr, pal_wdata};
    assign rgb_out    = rgb3_q;
`endif

    assign r       = rgb_out[23:16];
    assign g       = rgb_out[15:8];
    assign b       = rgb_out[7:0];
    assign hsync   = tim3_q.hsync;
    assign vsync   = tim3_q.vsync;
    assign blank_b = tim3_q.blank_b;
    assign sync_b  = sync_b3_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: pixel-level model feeding a 3-deep output scoreboard.
`timescale 1ns/1ps
module tb_vga_pixel_pipe;

    localparam int unsigned WinX0  = 196;
    localparam int unsigned WinY0  = 116;
    localparam int unsigned WinW   = 253;
    localparam int unsigned WinH   = 249;
    localparam int unsigned Total  = 62997;
    localparam logic [23:0] Border = 24'h202020;

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    localparam exp_t ResetExp = '{px: 10'd0, py: 10'd0, rgb: 24'h0, hs: 1'b1, vs: 1'b1, bl: 1'b0};

    logic        vgaclk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_b_in = 1'b0, hold_in = 1'b1;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_wdata = '0;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, blank_b, sync_b, frame_done, err;

    vga_pixel_pipe_if fb ();

    vga_pixel_pipe #(
        .WIN_X0    (WinX0),
        .WIN_Y0    (WinY0),
        .WIN_W     (WinW),
        .WIN_H     (WinH),
        .BORDER_RGB(Border)
    ) dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .blank_b_in(blank_b_in),
        .hold_in   (hold_in),
        .rd_en     (fb.rd_en),
        .rd_addr   (fb.rd_addr),
        .rd_data   (fb.rd_data),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .r         (r),
        .g         (g),
        .b         (b),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank_b   (blank_b),
        .sync_b    (sync_b),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 vgaclk = ~vgaclk;

    // Framebuffer model: byte at address A is A[7:0], presented while rd_en is high.
    always @(negedge vgaclk) begin
        fb.rd_data = fb.rd_en ? fb.rd_addr[7:0] : 8'hA5;
    end

    int   errors = 0;
    int   checks = 0;
    int   rd_en_count = 0;
    int   fd_count = 0;
    exp_t sb_q[$];
    bit   m_run = 1'b0;
    bit   m_err = 1'b0;
    int   m_cnt = 0;
`ifdef VGA_PIXEL_PALETTE_EN
    logic [23:0] pal_m [256];
`endif

    function automatic logic [23:0] exp_colour(input logic [7:0] d);
`ifdef VGA_PIXEL_PALETTE_EN
        return pal_m[d];
`else
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
`endif
    endfunction

    task automatic drive_pixel(input int px, input int py, input bit do_rst);
        logic vis, win, exp_fetch, exp_fd;
        int   exp_addr;
        exp_t e;
        vis        = (px < 640) && (py < 480);
        win        = (px >= WinX0) && (px < WinX0 + WinW) && (py >= WinY0) && (py < WinY0 + WinH);
        x          = 10'(px);
        y          = 10'(py);
        hsync_in   = !((px >= 656) && (px < 752));
        vsync_in   = !((py >= 490) && (py < 492));
        blank_b_in = vis;
        hold_in    = !win;
        rst        = do_rst;
        exp_fetch  = 1'b0;
        exp_fd     = 1'b0;
        exp_addr   = 0;
        if (do_rst) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_err = 1'b0;
            sb_q.delete();
            repeat (3) sb_q.push_back(ResetExp);
        end else begin
            if (px == 0 && py == 0) begin
                if (m_run && m_cnt != 0 && m_cnt != Total) m_err = 1'b1;
                m_run = 1'b1;
                m_cnt = 0;
            end
            exp_fetch = m_run && win && vis;
            exp_addr  = m_cnt;
            exp_fd    = exp_fetch && (m_cnt == Total - 1);
            e.px      = 10'(px);
            e.py      = 10'(py);
            e.hs      = hsync_in;
            e.vs      = vsync_in;
            e.bl      = vis;
            e.rgb     = exp_fetch ? exp_colour(m_cnt[7:0]) : (vis ? Border : 24'h0);
            if (exp_fetch) m_cnt++;
            sb_q.push_back(e);
        end

        @(posedge vgaclk);
        #1;
        checks++;
        if (fb.rd_en !== exp_fetch) begin
            errors++;
            $display("FAIL rd_en at (%0d,%0d): got %b expected %b", px, py, fb.rd_en, exp_fetch);
        end
        if (exp_fetch || do_rst) begin
            checks++;
            if (fb.rd_addr !== 16'(exp_addr)) begin
                errors++;
                $display("FAIL rd_addr at (%0d,%0d): got %0d expected %0d", px, py, fb.rd_addr,
                         exp_addr);
            end
        end
        checks++;
        if (frame_done !== exp_fd) begin
            errors++;
            $display("FAIL frame_done at (%0d,%0d): got %b expected %b", px, py, frame_done, exp_fd);
        end
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL err at (%0d,%0d): got %b expected %b", px, py, err, m_err);
        end
        if (sb_q.size() >= 3) begin
            e = sb_q.pop_front();
            checks++;
            if ({r, g, b} !== e.rgb) begin
                errors++;
                $display("FAIL pixel_rgb for (%0d,%0d): got %06h expected %06h", e.px, e.py,
                         {r, g, b}, e.rgb);
            end
            checks++;
            if ({hsync, vsync, blank_b, sync_b} !== {e.hs, e.vs, e.bl, e.hs & e.vs}) begin
                errors++;
                $display("FAIL timing for (%0d,%0d): got hs/vs/bl/sb %b%b%b%b expected %b%b%b%b",
                         e.px, e.py, hsync, vsync, blank_b, sync_b, e.hs, e.vs, e.bl, e.hs & e.vs);
            end
        end
        if (fb.rd_en === 1'b1) rd_en_count++;
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic test_reset();
        repeat (3) drive_pixel(700, 500, 1'b1);
        drive_pixel(700, 500, 1'b0);
    endtask

    task automatic test_palette_load();
`ifdef VGA_PIXEL_PALETTE_EN
        for (int i = 0; i < 256; i++) begin
            pal_we    = 1'b1;
            pal_addr  = 8'(i);
            pal_wdata = (i == 5) ? 24'hFF8000 : {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A};
            pal_m[i]  = pal_wdata;
            drive_pixel(700, 500, 1'b0);
        end
        pal_we = 1'b0;
        drive_pixel(700, 500, 1'b0);
`endif
    endtask

    // Full frame with horizontal blanking compressed to a few sample columns per row.
    task automatic test_full_frame();
        int fetch0, fd0;
        fetch0 = rd_en_count;
        fd0    = fd_count;
        for (int yy = 0; yy < 525; yy++) begin
            if (yy >= int'(WinY0) && yy < int'(WinY0 + WinH)) begin
                drive_pixel(0, yy, 1'b0);
                drive_pixel(10, yy, 1'b0);
                drive_pixel(195, yy, 1'b0);
                for (int xx = WinX0; xx < int'(WinX0 + WinW); xx++) drive_pixel(xx, yy, 1'b0);
                drive_pixel(449, yy, 1'b0);
                drive_pixel(656, yy, 1'b0);
                drive_pixel(700, yy, 1'b0);
                drive_pixel(752, yy, 1'b0);
            end else begin
                drive_pixel(0, yy, 1'b0);
                drive_pixel(10, yy, 1'b0);
                drive_pixel(300, yy, 1'b0);
                drive_pixel(656, yy, 1'b0);
                drive_pixel(700, yy, 1'b0);
            end
        end
        drive_pixel(0, 0, 1'b0);
        checks++;
        if (rd_en_count - fetch0 != Total) begin
            errors++;
            $display("FAIL frame_fetch_count: got %0d expected %0d", rd_en_count - fetch0, Total);
        end
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 1", fd_count - fd0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL clean_frame_err: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_midframe();
        int fetch0;
        for (int xx = 196; xx < 201; xx++) drive_pixel(xx, 116, 1'b0);
        drive_pixel(300, 200, 1'b1);
        drive_pixel(300, 200, 1'b1);
        fetch0 = rd_en_count;
        for (int xx = 300; xx < 304; xx++) drive_pixel(xx, 201, 1'b0);
        drive_pixel(700, 201, 1'b0);
        checks++;
        if (rd_en_count != fetch0) begin
            errors++;
            $display("FAIL fetch_after_reset: got %0d fetches expected 0", rd_en_count - fetch0);
        end
        drive_pixel(0, 0, 1'b0);
        for (int xx = 196; xx < 204; xx++) drive_pixel(xx, 116, 1'b0);
        checks++;
        if (fb.rd_addr !== 16'd7) begin
            errors++;
            $display("FAIL restart_addr: got %0d expected 7", fb.rd_addr);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
    endtask

    task automatic test_truncated_frame();
        drive_pixel(0, 0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL truncated_err: got %b expected 1", err);
        end
        drive_pixel(0, 0, 1'b0);
        for (int xx = 196; xx < 200; xx++) drive_pixel(xx, 116, 1'b0);
        drive_pixel(10, 10, 1'b0);
        drive_pixel(700, 10, 1'b0);
        repeat (3) drive_pixel(700, 500, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL sticky_err: got %b expected 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_palette_load();
        test_full_frame();
        test_reset_midframe();
        test_truncated_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
